// File: rtl/opicorv32_pkg.sv
// Shared encodings and bundle types for the ALU decode stage.
package opicorv32_pkg;

    // Major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // funct3 for OP / OP-IMM
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct3 for BRANCH
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct3 for JALR
    localparam logic [2:0] F3_JALR = 3'b000;

    // funct7 variants
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        logic is_lui_auipc_jal_jalr_addi_add;
        logic is_slti_blt_slt;
        logic is_sltiu_bltu_sltu;
        logic is_compare;
        logic instr_beq;
        logic instr_bne;
        logic instr_bge;
        logic instr_bgeu;
        logic instr_xori;
        logic instr_ori;
        logic instr_andi;
        logic instr_sub;
        logic instr_xor;
        logic instr_or;
        logic instr_and;
    } alu_flags_t;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        alu_flags_t  flags;
        logic        illegal;
    } alu_bundle_t;

endpackage

// File: rtl/opicorv32_imm_decode.sv
// Immediate extraction: sign-extended I-type and upper U-type immediates.
// Only instr[31:12] carries immediate bits for these two formats.
module opicorv32_imm_decode (
    input  logic [31:12] instr,
    output logic [31:0]  imm_i,
    output logic [31:0]  imm_u
);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_u = {instr[31:12], 12'b0};

endmodule

// File: rtl/opicorv32_alu_decode.sv
// Single registered stage turning an instruction plus operands into the
// ALU control bundle (operand selection and operation flags).
module opicorv32_alu_decode
    import opicorv32_pkg::*;
#(
    parameter bit CATCH_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] reg_op1,
    output logic [31:0] reg_op2,
    output logic        is_lui_auipc_jal_jalr_addi_add,
    output logic        is_slti_blt_slt,
    output logic        is_sltiu_bltu_sltu,
    output logic        is_compare,
    output logic        instr_beq,
    output logic        instr_bne,
    output logic        instr_bge,
    output logic        instr_bgeu,
    output logic        instr_xori,
    output logic        instr_ori,
    output logic        instr_andi,
    output logic        instr_sub,
    output logic        instr_xor,
    output logic        instr_or,
    output logic        instr_and,
    output logic        out_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic        supported;
    logic        unused_rd_bits;
    alu_bundle_t dec;
    alu_bundle_t bundle_q;
    logic        valid_q;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // rd is not needed to build ALU controls
    assign unused_rd_bits = ^instr[11:7];

    opicorv32_imm_decode u_imm (
        .instr (instr[31:12]),
        .imm_i (imm_i),
        .imm_u (imm_u)
    );

    // Decode operands and flags; anything not recognised collapses to zero
    always_comb begin
        dec       = '0;
        supported = 1'b0;
        case (opcode)
            OPC_LUI: begin
                supported = 1'b1;
                dec.op2   = imm_u;
                dec.flags.is_lui_auipc_jal_jalr_addi_add = 1'b1;
            end
            OPC_AUIPC: begin
                supported = 1'b1;
                dec.op1   = pc;
                dec.op2   = imm_u;
                dec.flags.is_lui_auipc_jal_jalr_addi_add = 1'b1;
            end
            OPC_JAL: begin
                supported = 1'b1;
                dec.op1   = pc;
                dec.op2   = 32'd4;
                dec.flags.is_lui_auipc_jal_jalr_addi_add = 1'b1;
            end
            OPC_JALR: begin
                supported = (funct3 == F3_JALR);
                dec.op1   = pc;
                dec.op2   = 32'd4;
                dec.flags.is_lui_auipc_jal_jalr_addi_add = 1'b1;
            end
            OPC_BRANCH: begin
                supported = 1'b1;
                dec.op1   = rs1_data;
                dec.op2   = rs2_data;
                dec.flags.is_compare = 1'b1;
                case (funct3)
                    F3_BEQ:  dec.flags.instr_beq          = 1'b1;
                    F3_BNE:  dec.flags.instr_bne          = 1'b1;
                    F3_BLT:  dec.flags.is_slti_blt_slt    = 1'b1;
                    F3_BGE:  dec.flags.instr_bge          = 1'b1;
                    F3_BLTU: dec.flags.is_sltiu_bltu_sltu = 1'b1;
                    F3_BGEU: dec.flags.instr_bgeu         = 1'b1;
                    default: supported = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                supported = 1'b1;
                dec.op1   = rs1_data;
                dec.op2   = imm_i;
                case (funct3)
                    F3_ADD:  dec.flags.is_lui_auipc_jal_jalr_addi_add = 1'b1;
                    F3_SLT: begin
                        dec.flags.is_slti_blt_slt = 1'b1;
                        dec.flags.is_compare      = 1'b1;
                    end
                    F3_SLTU: begin
                        dec.flags.is_sltiu_bltu_sltu = 1'b1;
                        dec.flags.is_compare         = 1'b1;
                    end
                    F3_XOR:  dec.flags.instr_xori = 1'b1;
                    F3_OR:   dec.flags.instr_ori  = 1'b1;
                    F3_AND:  dec.flags.instr_andi = 1'b1;
                    // shifts (F3_SLL, F3_SR) are handled elsewhere
                    default: supported = 1'b0;
                endcase
            end
            OPC_OP: begin
                dec.op1 = rs1_data;
                dec.op2 = rs2_data;
                if (funct7 == F7_BASE) begin
                    supported = 1'b1;
                    case (funct3)
                        F3_ADD:  dec.flags.is_lui_auipc_jal_jalr_addi_add = 1'b1;
                        F3_SLT: begin
                            dec.flags.is_slti_blt_slt = 1'b1;
                            dec.flags.is_compare      = 1'b1;
                        end
                        F3_SLTU: begin
                            dec.flags.is_sltiu_bltu_sltu = 1'b1;
                            dec.flags.is_compare         = 1'b1;
                        end
                        F3_XOR:  dec.flags.instr_xor = 1'b1;
                        F3_OR:   dec.flags.instr_or  = 1'b1;
                        F3_AND:  dec.flags.instr_and = 1'b1;
                        default: supported = 1'b0;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    supported = 1'b1;
                    dec.flags.instr_sub = 1'b1;
                end
            end
            default: supported = 1'b0;
        endcase

        if (!supported) begin
            dec         = '0;
            dec.illegal = CATCH_ILLEGAL;
        end
    end

    assign in_ready = !valid_q || out_ready;

    // Pipeline register: load on accept, drop valid when drained without refill
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else if (in_valid && in_ready) begin
            valid_q  <= 1'b1;
            bundle_q <= dec;
        end else if (out_ready) begin
            valid_q  <= 1'b0;
        end
    end

    assign out_valid   = valid_q;
    assign reg_op1     = bundle_q.op1;
    assign reg_op2     = bundle_q.op2;
    assign out_illegal = bundle_q.illegal;

    assign is_lui_auipc_jal_jalr_addi_add = bundle_q.flags.is_lui_auipc_jal_jalr_addi_add;
    assign is_slti_blt_slt    = bundle_q.flags.is_slti_blt_slt;
    assign is_sltiu_bltu_sltu = bundle_q.flags.is_sltiu_bltu_sltu;
    assign is_compare         = bundle_q.flags.is_compare;
    assign instr_beq          = bundle_q.flags.instr_beq;
    assign instr_bne          = bundle_q.flags.instr_bne;
    assign instr_bge          = bundle_q.flags.instr_bge;
    assign instr_bgeu         = bundle_q.flags.instr_bgeu;
    assign instr_xori         = bundle_q.flags.instr_xori;
    assign instr_ori          = bundle_q.flags.instr_ori;
    assign instr_andi         = bundle_q.flags.instr_andi;
    assign instr_sub          = bundle_q.flags.instr_sub;
    assign instr_xor          = bundle_q.flags.instr_xor;
    assign instr_or           = bundle_q.flags.instr_or;
    assign instr_and          = bundle_q.flags.instr_and;

endmodule

// File: tb/tb_opicorv32_alu_decode.sv
// Bench for the ALU decode stage: directed scenarios plus a random stream
// checked against a reference decoder through an expected-result queue.
module tb_opicorv32_alu_decode;

    localparam int F_LUI  = 14;
    localparam int F_SLT  = 13;
    localparam int F_SLTU = 12;
    localparam int F_CMP  = 11;
    localparam int F_BEQ  = 10;
    localparam int F_BNE  = 9;
    localparam int F_BGE  = 8;
    localparam int F_BGEU = 7;
    localparam int F_XORI = 6;
    localparam int F_ORI  = 5;
    localparam int F_ANDI = 4;
    localparam int F_SUB  = 3;
    localparam int F_XOR  = 2;
    localparam int F_OR   = 1;
    localparam int F_AND  = 0;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [14:0] flags;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr, pc, rs1_data, rs2_data;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] reg_op1, reg_op2;
    logic        f_lui, f_slt, f_sltu, f_cmp, f_beq, f_bne, f_bge, f_bgeu;
    logic        f_xori, f_ori, f_andi, f_sub, f_xor, f_or, f_and;

    logic        nc_in_ready, nc_out_valid, nc_out_illegal;
    logic [31:0] nc_reg_op1, nc_reg_op2;
    logic        n_lui, n_slt, n_sltu, n_cmp, n_beq, n_bne, n_bge, n_bgeu;
    logic        n_xori, n_ori, n_andi, n_sub, n_xor, n_or, n_and;

    exp_t exp_q[$];
    exp_t nc_q[$];
    int   checks   = 0;
    int   failures = 0;

    opicorv32_alu_decode dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .reg_op1(reg_op1), .reg_op2(reg_op2),
        .is_lui_auipc_jal_jalr_addi_add(f_lui), .is_slti_blt_slt(f_slt),
        .is_sltiu_bltu_sltu(f_sltu), .is_compare(f_cmp),
        .instr_beq(f_beq), .instr_bne(f_bne), .instr_bge(f_bge), .instr_bgeu(f_bgeu),
        .instr_xori(f_xori), .instr_ori(f_ori), .instr_andi(f_andi),
        .instr_sub(f_sub), .instr_xor(f_xor), .instr_or(f_or), .instr_and(f_and),
        .out_illegal(out_illegal)
    );

    opicorv32_alu_decode #(.CATCH_ILLEGAL(1'b0)) dut_nc (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(nc_in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(nc_out_valid), .out_ready(out_ready),
        .reg_op1(nc_reg_op1), .reg_op2(nc_reg_op2),
        .is_lui_auipc_jal_jalr_addi_add(n_lui), .is_slti_blt_slt(n_slt),
        .is_sltiu_bltu_sltu(n_sltu), .is_compare(n_cmp),
        .instr_beq(n_beq), .instr_bne(n_bne), .instr_bge(n_bge), .instr_bgeu(n_bgeu),
        .instr_xori(n_xori), .instr_ori(n_ori), .instr_andi(n_andi),
        .instr_sub(n_sub), .instr_xor(n_xor), .instr_or(n_or), .instr_and(n_and),
        .out_illegal(nc_out_illegal)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t obs_dut();
        return {reg_op1, reg_op2, f_lui, f_slt, f_sltu, f_cmp, f_beq, f_bne, f_bge, f_bgeu,
                f_xori, f_ori, f_andi, f_sub, f_xor, f_or, f_and, out_illegal};
    endfunction

    function automatic exp_t obs_nc();
        return {nc_reg_op1, nc_reg_op2, n_lui, n_slt, n_sltu, n_cmp, n_beq, n_bne, n_bge, n_bgeu,
                n_xori, n_ori, n_andi, n_sub, n_xor, n_or, n_and, nc_out_illegal};
    endfunction

    // Reference decoder, written from the instruction set tables
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input bit catch_ill);
        exp_t        e;
        logic        ok;
        logic [31:0] ii, uu;
        e  = '0;
        ok = 1'b1;
        ii = {{20{i[31]}}, i[31:20]};
        uu = {i[31:12], 12'h000};
        casez ({i[31:25], i[14:12], i[6:0]})
            17'b???????_???_0110111: e.flags[F_LUI] = 1'b1;
            17'b???????_???_0010111: e.flags[F_LUI] = 1'b1;
            17'b???????_???_1101111: e.flags[F_LUI] = 1'b1;
            17'b???????_000_1100111: e.flags[F_LUI] = 1'b1;
            17'b???????_000_1100011: begin e.flags[F_CMP] = 1'b1; e.flags[F_BEQ]  = 1'b1; end
            17'b???????_001_1100011: begin e.flags[F_CMP] = 1'b1; e.flags[F_BNE]  = 1'b1; end
            17'b???????_100_1100011: begin e.flags[F_CMP] = 1'b1; e.flags[F_SLT]  = 1'b1; end
            17'b???????_101_1100011: begin e.flags[F_CMP] = 1'b1; e.flags[F_BGE]  = 1'b1; end
            17'b???????_110_1100011: begin e.flags[F_CMP] = 1'b1; e.flags[F_SLTU] = 1'b1; end
            17'b???????_111_1100011: begin e.flags[F_CMP] = 1'b1; e.flags[F_BGEU] = 1'b1; end
            17'b???????_000_0010011: e.flags[F_LUI] = 1'b1;
            17'b???????_010_0010011: begin e.flags[F_CMP] = 1'b1; e.flags[F_SLT]  = 1'b1; end
            17'b???????_011_0010011: begin e.flags[F_CMP] = 1'b1; e.flags[F_SLTU] = 1'b1; end
            17'b???????_100_0010011: e.flags[F_XORI] = 1'b1;
            17'b???????_110_0010011: e.flags[F_ORI]  = 1'b1;
            17'b???????_111_0010011: e.flags[F_ANDI] = 1'b1;
            17'b0000000_000_0110011: e.flags[F_LUI] = 1'b1;
            17'b0000000_010_0110011: begin e.flags[F_CMP] = 1'b1; e.flags[F_SLT]  = 1'b1; end
            17'b0000000_011_0110011: begin e.flags[F_CMP] = 1'b1; e.flags[F_SLTU] = 1'b1; end
            17'b0000000_100_0110011: e.flags[F_XOR] = 1'b1;
            17'b0000000_110_0110011: e.flags[F_OR]  = 1'b1;
            17'b0000000_111_0110011: e.flags[F_AND] = 1'b1;
            17'b0100000_000_0110011: e.flags[F_SUB] = 1'b1;
            default: ok = 1'b0;
        endcase
        case (i[6:0])
            7'b0110111: begin e.op1 = 32'h0; e.op2 = uu;    end
            7'b0010111: begin e.op1 = p;     e.op2 = uu;    end
            7'b1101111,
            7'b1100111: begin e.op1 = p;     e.op2 = 32'd4; end
            7'b0010011: begin e.op1 = r1;    e.op2 = ii;    end
            default:    begin e.op1 = r1;    e.op2 = r2;    end
        endcase
        if (!ok) begin
            e     = '0;
            e.ill = catch_ill;
        end
        return e;
    endfunction

    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; instr = i; pc = p; rs1_data = a; rs2_data = b;
        exp_q.push_back(model(i, p, a, b, 1'b1));
    endtask

    task automatic test_reset();
        exp_t o;
        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
        repeat (2) @(negedge clk);
        o = obs_dut();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (o !== '0) begin failures++; $display("FAIL reset_bundle: got %h want 0", o); end
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_addi();
        exp_t o, e;
        out_ready = 1'b1;
        drive(32'h00500093, 32'h40, 32'h0, 32'hDEAD_BEEF);
        @(negedge clk);
        in_valid = 1'b0;
        o = obs_dut(); e = exp_q.pop_front();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid: got %b want 1", out_valid); end
        checks++; if (o !== e) begin failures++; $display("FAIL addi_bundle: got %h want %h", o, e); end
        checks++; if (reg_op2 !== 32'd5 || f_lui !== 1'b1) begin
            failures++; $display("FAIL addi_fields: got op2=%h flag=%b want op2=5 flag=1", reg_op2, f_lui);
        end
    endtask

    task automatic test_lui_auipc();
        exp_t o, e;
        out_ready = 1'b1;
        drive(32'h12345037, 32'h100, 32'h1111, 32'h2222);
        @(negedge clk);
        o = obs_dut(); e = exp_q.pop_front();
        checks++; if (o !== e) begin failures++; $display("FAIL lui_bundle: got %h want %h", o, e); end
        checks++; if (reg_op1 !== 32'h0 || reg_op2 !== 32'h12345000) begin
            failures++; $display("FAIL lui_ops: got %h/%h want 0/12345000", reg_op1, reg_op2);
        end
        drive(32'h12345017, 32'h100, 32'h1111, 32'h2222);
        @(negedge clk);
        in_valid = 1'b0;
        o = obs_dut(); e = exp_q.pop_front();
        checks++; if (out_valid !== 1'b1 || o !== e) begin failures++; $display("FAIL auipc_bundle: got %b/%h want 1/%h", out_valid, o, e); end
        checks++; if (reg_op1 !== 32'h100) begin failures++; $display("FAIL auipc_op1: got %h want 100", reg_op1); end
    endtask

    task automatic test_blt();
        exp_t o, e;
        out_ready = 1'b1;
        drive(32'h0020C463, 32'h200, 32'd5, 32'd7);
        @(negedge clk);
        in_valid = 1'b0;
        o = obs_dut(); e = exp_q.pop_front();
        checks++; if (o !== e) begin failures++; $display("FAIL blt_bundle: got %h want %h", o, e); end
        checks++; if (f_slt !== 1'b1 || f_cmp !== 1'b1 || reg_op1 !== 32'd5 || reg_op2 !== 32'd7) begin
            failures++; $display("FAIL blt_fields: got slt=%b cmp=%b op1=%h op2=%h want 1 1 5 7", f_slt, f_cmp, reg_op1, reg_op2);
        end
    endtask

    task automatic test_back_to_back();
        exp_t o, e, hold;
        out_ready = 1'b1;
        drive(32'h40208033, 32'h300, 32'd9, 32'd4);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h0020C1B3; rs1_data = 32'hA5A5_0000; rs2_data = 32'h0000_5A5A;
        hold = obs_dut();
        checks++; if (out_valid !== 1'b1 || hold !== exp_q[0]) begin
            failures++; $display("FAIL sub_bundle: got %b/%h want 1/%h", out_valid, hold, exp_q[0]);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            o = obs_dut();
            checks++; if (out_valid !== 1'b1 || o !== hold || in_ready !== 1'b0) begin
                failures++; $display("FAIL stall_hold: got v=%b rdy=%b %h want v=1 rdy=0 %h", out_valid, in_ready, o, hold);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL drain_ready: got %b want 1", in_ready); end
        e = exp_q.pop_front();
        exp_q.push_back(model(instr, pc, rs1_data, rs2_data, 1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        o = obs_dut(); e = exp_q.pop_front();
        checks++; if (out_valid !== 1'b1 || o !== e) begin
            failures++; $display("FAIL no_bubble: got %b/%h want 1/%h", out_valid, o, e);
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        exp_t o, e;
        out_ready = 1'b1;
        drive(32'h00109093, 32'h400, 32'h55, 32'h66);
        @(negedge clk);
        in_valid = 1'b0;
        o = obs_dut(); e = exp_q.pop_front();
        checks++; if (out_valid !== 1'b1 || o !== e) begin failures++; $display("FAIL slli_bundle: got %b/%h want 1/%h", out_valid, o, e); end
        checks++; if (out_illegal !== 1'b1 || o.flags !== 15'h0) begin
            failures++; $display("FAIL slli_illegal: got ill=%b flags=%h want 1/0", out_illegal, o.flags);
        end
        checks++; if (nc_out_valid !== 1'b1 || obs_nc() !== '0) begin
            failures++; $display("FAIL slli_nocatch: got %b/%h want 1/0", nc_out_valid, obs_nc());
        end
    endtask

    task automatic test_reset_mid_stall();
        exp_t o;
        out_ready = 1'b1;
        drive(32'h0020F1B3, 32'h500, 32'hF0F0, 32'hFF00);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        o = obs_dut();
        checks++; if (out_valid !== 1'b0 || o !== '0) begin
            failures++; $display("FAIL async_reset: got %b/%h want 0/0", out_valid, o);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stale_issue: got %b want 0", out_valid); end
        end
    endtask

    task automatic test_stream();
        bit          mv = 1'b0;
        bit          acc;
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [31:0] w;
        exp_t        o, n;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== mv) begin failures++; $display("FAIL stream_valid: cycle %0d got %b want %b", c, out_valid, mv); end
            if (mv) begin
                o = obs_dut(); n = obs_nc();
                checks++; if (o !== exp_q[0] || n !== nc_q[0]) begin
                    failures++; $display("FAIL stream_bundle: cycle %0d got %h/%h want %h/%h", c, o, n, exp_q[0], nc_q[0]);
                end
            end
            case ($urandom_range(0, 12))
                0: opc = 7'b0110111;  1: opc = 7'b0010111;  2: opc = 7'b1101111;
                3: opc = 7'b1100111;  4: opc = 7'b1100011;  5: opc = 7'b0010011;
                6: opc = 7'b0110011;  7: opc = 7'b0110011;  8: opc = 7'b0000011;
                9: opc = 7'b0100011; 10: opc = 7'b1110011; 11: opc = 7'b0001111;
                default: opc = 7'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0, 1: f7 = 7'h00;
                2:    f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            w = $urandom;
            w[6:0] = opc;
            w[31:25] = f7;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            instr = w; pc = $urandom; rs1_data = $urandom; rs2_data = $urandom;
            #1;
            checks++; if (in_ready !== (!mv || out_ready)) begin
                failures++; $display("FAIL stream_ready: cycle %0d got %b want %b", c, in_ready, !mv || out_ready);
            end
            acc = in_valid && (!mv || out_ready);
            if (mv && out_ready) begin
                void'(exp_q.pop_front());
                void'(nc_q.pop_front());
            end
            if (acc) begin
                exp_q.push_back(model(instr, pc, rs1_data, rs2_data, 1'b1));
                nc_q.push_back(model(instr, pc, rs1_data, rs2_data, 1'b0));
            end
            mv = acc ? 1'b1 : (out_ready ? 1'b0 : mv);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lui_auipc();
        test_blt();
        test_back_to_back();
        test_illegal();
        test_reset_mid_stall();
        test_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/opicorv32_alu_decode.md
OPICORV32_ALU_DECODE -- requirements
Module: opicorv32_alu_decode

Interface
REQ-001 SHALL have parameter CATCH_ILLEGAL, default 1: when 1, unsupported encodings raise out_illegal; when 0, they issue as all-zero control.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1: instruction and operands are valid.
REQ-005 SHALL have port in_ready, output, 1: stage accepts this cycle.
REQ-006 SHALL have ports instr (input, 32), pc (input, 32), rs1_data (input, 32) and rs2_data (input, 32): the raw instruction word, its PC and the register-file read data.
REQ-007 SHALL have port out_valid, output, 1: the ALU control bundle is valid.
REQ-008 SHALL have port out_ready, input, 1: the downstream ALU stage consumes the bundle.
REQ-009 SHALL have ports reg_op1 and reg_op2, output, 32 each: the ALU operands.
REQ-010 SHALL have output ports, 1 bit each: is_lui_auipc_jal_jalr_addi_add, is_slti_blt_slt, is_sltiu_bltu_sltu, is_compare, instr_beq, instr_bne, instr_bge, instr_bgeu, instr_xori, instr_ori, instr_andi, instr_sub, instr_xor, instr_or, instr_and.
REQ-011 SHALL have port out_illegal, output, 1: the issued word is unsupported.

Function
REQ-012 SHALL be a single registered pipeline stage with in_ready = !out_valid || out_ready.
REQ-013 SHALL capture the decoded bundle on in_valid && in_ready; out_valid is set the next cycle, so latency is 1 cycle.
REQ-014 SHALL clear out_valid on out_ready when no new accept occurs in the same cycle; a simultaneous drain and accept keeps out_valid=1 and loads the new bundle.
REQ-015 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-016 SHALL select operands as follows:
- LUI: op1=0, op2=U-imm
- AUIPC: op1=pc, op2=U-imm
- JAL/JALR: op1=pc, op2=4
- OP-IMM: op1=rs1, op2=sign-extended I-imm
- OP and BRANCH: op1=rs1, op2=rs2
REQ-017 SHALL drive is_lui_auipc_jal_jalr_addi_add for LUI, AUIPC, JAL, JALR, ADDI and ADD.
REQ-018 SHALL drive is_slti_blt_slt for SLTI, BLT and SLT, and is_sltiu_bltu_sltu for SLTIU, BLTU and SLTU.
REQ-019 SHALL drive is_compare for all six branches plus SLTI, SLTIU, SLT and SLTU.
REQ-020 SHALL drive the instr_* flags one-hot from opcode/funct3/funct7.
REQ-021 SHALL treat shifts, loads, stores, SYSTEM, FENCE and any other encoding as unsupported: all control flags 0, both operands 0, out_illegal=CATCH_ILLEGAL.
REQ-022 SHALL treat OP with funct7 other than 0x00, or 0x20 with funct3=000, as unsupported.
REQ-023 SHALL ignore instr, pc and rs*_data when in_valid=0.

Reset
REQ-024 SHALL, while resetn=0, force out_valid=0, out_illegal=0, all flags 0 and both operands 0, asynchronously.
REQ-025 SHALL discard a bundle held at reset assertion; in_ready=1 in the first cycle after release.

Structure
REQ-026 SHALL take opcode, funct3 and funct7 constants from the shared package opicorv32_pkg.
REQ-027 SHALL compute immediates in the combinational sub-module opicorv32_imm_decode (instr -> I-imm and U-imm, 32 bits each).

Verification
REQ-028 SHALL cover: instr=0x00500093 (addi x1,x0,5), rs1_data=0 -> next cycle out_valid=1, reg_op2=5, is_lui_auipc_jal_jalr_addi_add=1, all others 0.
REQ-029 SHALL cover: instr=0x12345037, pc=0x100 -> reg_op1=0, reg_op2=0x12345000. Then instr=0x12345017 -> reg_op1=0x100.
REQ-030 SHALL cover: instr=0x0020C463 (blt), rs1_data=5, rs2_data=7 -> is_slti_blt_slt=1, is_compare=1, reg_op1=5, reg_op2=7.
REQ-031 SHALL cover: instr=0x40208033 (sub) with out_ready=0 for 3 cycles -> outputs stable, in_ready=0. out_ready=1 together with a new in_valid -> back-to-back issue with no bubble.
REQ-032 SHALL cover: instr=0x00109093 (slli) -> out_illegal=1, all flags 0. With CATCH_ILLEGAL=0 -> out_illegal=0.
REQ-033 SHALL cover: resetn pulsed low mid-stall -> out_valid drops immediately; after release in_ready=1 and the prior bundle is never issued.
